// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a 4-digit BCD countdown onto a
// common-anode seven-segment display.
//  - The four digits are latched together at each frame boundary, so a digit
//    cannot change in the middle of a frame.
//  - zero_flag reports an all-zero snapshot. timeout_pulse marks the 0->1
//    transition of zero_flag.
//  - Optional feature: define SEG7_BLINK_ON_ZERO_EN to blink the display
//    every BLINK_FRAMES frames while zero_flag is set.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 124999,
  parameter int DP_DIGIT     = 2,
  parameter int LZB          = 1,
  parameter int BLINK_FRAMES = 63
) (
  input  logic       segclk,
  input  logic       resetn,
  input  logic       disp_en,
  input  logic [3:0] cnt_msec1,
  input  logic [3:0] cnt_msec10,
  input  logic [3:0] cnt_sec1,
  input  logic [3:0] cnt_sec10,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       zero_flag,
  output logic       timeout_pulse
);

  localparam int            PW  = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [PW-1:0] TC  = PW'(SCAN_DIV);
  localparam logic [1:0]    DPI = 2'(DP_DIGIT);

  typedef logic [3:0] bcd_t;

  // Active-low {g,f,e,d,c,b,a}. Values outside BCD show a dash.
  function automatic logic [6:0] bcd2seg(input bcd_t d);
    case (d)
      4'd0:    bcd2seg = 7'b1000000;
      4'd1:    bcd2seg = 7'b1111001;
      4'd2:    bcd2seg = 7'b0100100;
      4'd3:    bcd2seg = 7'b0110000;
      4'd4:    bcd2seg = 7'b0011001;
      4'd5:    bcd2seg = 7'b0010010;
      4'd6:    bcd2seg = 7'b0000010;
      4'd7:    bcd2seg = 7'b1111000;
      4'd8:    bcd2seg = 7'b0000000;
      4'd9:    bcd2seg = 7'b0010000;
      default: bcd2seg = 7'b0111111;
    endcase
  endfunction

  logic [PW-1:0]  presc;
  logic           tick;
  logic [1:0]     idx;
  logic [1:0]     idx_nxt;
  logic           frame_wrap;
  bcd_t [3:0]     cnt_in;
  bcd_t [3:0]     snap;
  bcd_t [3:0]     snap_nxt;
  logic           zero_nxt;
  logic           blink_vis_nxt;

  assign tick       = (presc == TC);
  assign idx_nxt    = idx + 2'd1;
  assign frame_wrap = tick & (idx == 2'd3);

  // Digit i of the display maps to element i: 0 = msec1 ... 3 = sec10.
  assign cnt_in   = {cnt_sec10, cnt_sec1, cnt_msec10, cnt_msec1};
  assign snap_nxt = frame_wrap ? cnt_in : snap;
  assign zero_nxt = (cnt_in == '0);

  // Prescaler: one digit slot lasts SCAN_DIV+1 clocks.
  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn)   presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Digit index advances once per slot and wraps 3->0.
  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn)   idx <= 2'd0;
    else if (tick) idx <= idx_nxt;
  end

  // Frame snapshot, zero detect and the rising-edge timeout pulse.
  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn) begin
      snap          <= {4{4'd9}};
      zero_flag     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else if (frame_wrap) begin
      snap          <= cnt_in;
      zero_flag     <= zero_nxt;
      timeout_pulse <= zero_nxt & ~zero_flag;
    end else begin
      timeout_pulse <= 1'b0;
    end
  end

`ifdef SEG7_BLINK_ON_ZERO_EN
  localparam int            BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_nxt;
  logic          blink_vis;

  // Blink phase: the first zero frame is visible, then the state toggles
  // every BLINK_FRAMES frames. Any nonzero snapshot restarts it as visible.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_vis_nxt = blink_vis;
    if (frame_wrap) begin
      if (!zero_nxt || !zero_flag) begin
        blink_cnt_nxt = '0;
        blink_vis_nxt = 1'b1;
      end else if (blink_cnt == BLAST) begin
        blink_cnt_nxt = '0;
        blink_vis_nxt = ~blink_vis;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end
  end

  // Blink state register.
  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_vis <= blink_vis_nxt;
    end
  end
`else
  // Without the blink feature the display is always visible, and
  // BLINK_FRAMES has no effect.
  assign blink_vis_nxt = (BLINK_FRAMES != 0) | 1'b1;
`endif

  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  bcd_t       dig;
  logic       lzb_blank;
  logic       lit;

  // Next display word, built from the slot and snapshot that take effect on
  // this tick. Using them here means a new frame shows its new digits from
  // the first slot onward.
  always_comb begin
    dig       = snap_nxt[idx_nxt];
    lzb_blank = (LZB != 0) && (idx_nxt == 2'd3) && (dig == 4'd0);
    lit       = disp_en && !lzb_blank && blink_vis_nxt;
    an_nxt    = 4'b1111;
    if (lit) an_nxt = ~(4'b0001 << idx_nxt);
    seg_nxt   = lzb_blank ? 7'b1111111 : bcd2seg(dig);
    dp_nxt    = ~(lit && (idx_nxt == DPI));
  end

  // Output register: loads once per slot, one clock after tick.
  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver. Two instances are built, one with LZB=1
// and one with LZB=0, with SCAN_DIV=3. A behavioural model follows the
// outputs using the clock count since reset:
//  - slot k starts on clock k*(SCAN_DIV+1);
//  - the index is k mod 4;
//  - a frame begins whenever the index is 0.
module tb_seg7_scan_driver;
  localparam int SD = 3;
  localparam int P  = SD + 1;
  localparam int BF = 2;

  logic       segclk = 1'b0;
  logic       resetn;
  logic       disp_en;
  logic [3:0] cnt_msec1, cnt_msec10, cnt_sec1, cnt_sec10;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0, zf1, zf0, tp1, tp0;

  always #5 segclk = ~segclk;

  seg7_scan_driver #(.SCAN_DIV(SD), .DP_DIGIT(2), .LZB(1), .BLINK_FRAMES(BF)) u1 (
    .segclk(segclk), .resetn(resetn), .disp_en(disp_en),
    .cnt_msec1(cnt_msec1), .cnt_msec10(cnt_msec10), .cnt_sec1(cnt_sec1), .cnt_sec10(cnt_sec10),
    .an(an1), .seg(seg1), .dp(dp1), .zero_flag(zf1), .timeout_pulse(tp1));

  seg7_scan_driver #(.SCAN_DIV(SD), .DP_DIGIT(2), .LZB(0), .BLINK_FRAMES(BF)) u0 (
    .segclk(segclk), .resetn(resetn), .disp_en(disp_en),
    .cnt_msec1(cnt_msec1), .cnt_msec10(cnt_msec10), .cnt_sec1(cnt_sec1), .cnt_sec10(cnt_sec10),
    .an(an0), .seg(seg0), .dp(dp0), .zero_flag(zf0), .timeout_pulse(tp0));

  logic [6:0] dec_tab [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  // Model state.
  int         n;
  int         m_idx;
  bit         m_tick;
  logic [3:0] m_snap [4];
  bit         m_zf, m_pulse;
  int         zk;
  logic [3:0] e_an  [2];
  logic [6:0] e_seg [2];
  logic       e_dp  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_idx = 0; m_tick = 0; m_zf = 0; m_pulse = 0; zk = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd9;
    for (int l = 0; l < 2; l++) begin e_an[l] = 4'hF; e_seg[l] = 7'h7F; e_dp[l] = 1'b1; end
  endtask

  task automatic model_step();
    bit nz, vis, blank, lit;
    logic [3:0] d;
    m_tick = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    n++;
    m_pulse = 0;
    if (n % P == 0) begin
      m_tick = 1;
      m_idx  = (n / P) % 4;
      if (m_idx == 0) begin
        nz = (cnt_msec1 == 0) && (cnt_msec10 == 0) && (cnt_sec1 == 0) && (cnt_sec10 == 0);
        m_pulse = nz && !m_zf;
        zk = (nz && m_zf) ? zk + 1 : 0;
        m_zf = nz;
        m_snap[0] = cnt_msec1; m_snap[1] = cnt_msec10;
        m_snap[2] = cnt_sec1;  m_snap[3] = cnt_sec10;
      end
`ifdef SEG7_BLINK_ON_ZERO_EN
      vis = !m_zf || (((zk / BF) % 2) == 0);
`else
      vis = 1;
`endif
      for (int l = 0; l < 2; l++) begin
        d     = m_snap[m_idx];
        blank = (l == 1) && (m_idx == 3) && (d == 0);
        lit   = disp_en && !blank && vis;
        e_an[l]  = lit ? 4'(~(4'b0001 << m_idx)) : 4'hF;
        e_seg[l] = blank ? 7'h7F : dec_tab[d];
        e_dp[l]  = !(lit && m_idx == 2);
      end
    end
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic cyc();
    @(posedge segclk);
    model_step();
    #1;
    chk("an_lzb1",  32'(an1),  32'(e_an[1]));
    chk("seg_lzb1", 32'(seg1), 32'(e_seg[1]));
    chk("dp_lzb1",  32'(dp1),  32'(e_dp[1]));
    chk("an_lzb0",  32'(an0),  32'(e_an[0]));
    chk("seg_lzb0", 32'(seg0), 32'(e_seg[0]));
    chk("dp_lzb0",  32'(dp0),  32'(e_dp[0]));
    chk("zero_flag1", 32'(zf1), 32'(m_zf));
    chk("zero_flag0", 32'(zf0), 32'(m_zf));
    chk("pulse1", 32'(tp1), 32'(m_pulse));
    chk("pulse0", 32'(tp0), 32'(m_pulse));
    if (tp1) pulse_cnt++;
  endtask

  task automatic wait_slot(input int i);
    bit found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      cyc();
      if (m_tick && m_idx == i) found = 1;
    end
    chk("wait_slot_timeout", 32'(found), 32'd1);
  endtask

  task automatic set_in(input logic [3:0] s10, input logic [3:0] s1,
                        input logic [3:0] m10, input logic [3:0] m1);
    cnt_sec10 = s10; cnt_sec1 = s1; cnt_msec10 = m10; cnt_msec1 = m1;
  endtask

  function automatic logic [3:0] rnd_digit();
    return ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    resetn = 1'b0; disp_en = 1'b1;
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    model_reset();
    repeat (3) cyc();
    chk("rst_an",  32'(an1),  32'hF);
    chk("rst_seg", 32'(seg1), 32'h7F);
    chk("rst_dp",  32'(dp1),  32'd1);
    chk("rst_zf",  32'(zf1),  32'd0);
    resetn = 1'b1;

    // A full frame of 1234, then a mid-frame change to 5678.
    wait_slot(0);
    chk("p1_an0",  32'(an1),  32'b1110);
    chk("p1_seg0", 32'(seg1), 32'b0011001);
    wait_slot(1);
    chk("p1_an1",  32'(an1),  32'b1101);
    chk("p1_seg1", 32'(seg1), 32'b0110000);
    set_in(4'd5, 4'd6, 4'd7, 4'd8);
    wait_slot(2);
    chk("p2_an2",  32'(an1),  32'b1011);
    chk("p2_seg2", 32'(seg1), 32'b0100100);
    chk("p2_dp2",  32'(dp1),  32'd0);
    wait_slot(3);
    chk("p2_seg3", 32'(seg1), 32'b1111001);
    wait_slot(0);
    chk("p2_new",  32'(seg1), 32'b0000000);

    // Leading-zero blanking.
    set_in(4'd0, 4'd9, 4'd5, 4'd0);
    wait_slot(0);
    wait_slot(3);
    chk("lzb1_an",  32'(an1),  32'hF);
    chk("lzb1_seg", 32'(seg1), 32'h7F);
    chk("lzb0_an",  32'(an0),  32'b0111);
    chk("lzb0_seg", 32'(seg0), 32'b1000000);

    // Non-BCD nibble, then display disable.
    set_in(4'd1, 4'd2, 4'hC, 4'd4);
    wait_slot(0);
    wait_slot(1);
    chk("dash_seg", 32'(seg1), 32'b0111111);
    disp_en = 1'b0;
    wait_slot(2);
    chk("dis_an", 32'(an1), 32'hF);
    disp_en = 1'b1;

    // Reach zero, hold, reload, and reach zero again.
    set_in(4'd0, 4'd0, 4'd0, 4'd0);
    pulse_cnt = 0;
    wait_slot(0);
    chk("zf_set", 32'(zf1), 32'd1);
    repeat (10) wait_slot(0);
    chk("one_pulse", 32'(pulse_cnt), 32'd1);
    set_in(4'd9, 4'd9, 4'd9, 4'd9);
    wait_slot(0);
    chk("zf_clr", 32'(zf1), 32'd0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0);
    wait_slot(0);
    chk("rearm_pulse", 32'(pulse_cnt), 32'd2);

    // Asynchronous reset in the middle of a slot.
    wait_slot(2);
    cyc();
    #1 resetn = 1'b0;
    #1;
    chk("arst_an",  32'(an1),  32'hF);
    chk("arst_seg", 32'(seg1), 32'h7F);
    chk("arst_dp",  32'(dp1),  32'd1);
    chk("arst_zf",  32'(zf1),  32'd0);
    repeat (2) cyc();
    resetn = 1'b1;
    wait_slot(1);
    chk("first_after_rst", 32'(an1), 32'b1101);

    // Random inputs, display enable and occasional zero stretches.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (c == 2000) resetn = 1'b0;
      if (c == 2003) resetn = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) set_in(4'd0, 4'd0, 4'd0, 4'd0);
        else set_in(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
      end
      if ($urandom_range(0, 15) == 0) disp_en = ~disp_en;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
